// File: rtl/apu_frame_sequencer.sv
// APU timing controller: 512 Hz frame sequencer plus fractional-N frequency-timer tick enables.
// Optional single-step debug ports (dbg_hold, dbg_step_req) when APU_FRAME_SINGLE_STEP_EN is defined.
module apu_frame_sequencer #(
    parameter int unsigned FRAME_DIV  = 24000,
    parameter int unsigned ACC_MOD    = 375,
    parameter int unsigned FREQ12_INC = 4,
    parameter int unsigned FREQ3_INC  = 2,
    parameter int unsigned ACC_W      = 9
) (
    input  logic       ac97_bitclk,
    input  logic       reset_b,
    input  logic       master_sound_enable,
`ifdef APU_FRAME_SINGLE_STEP_EN
    input  logic       dbg_hold,
    input  logic       dbg_step_req,
`endif
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic       freq12_tick,
    output logic       freq3_tick,
    output logic [2:0] frame_step
);

    localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [ACC_W-1:0] MOD_V    = ACC_W'(ACC_MOD);
    localparam logic [ACC_W-1:0] INC12_V  = ACC_W'(FREQ12_INC);
    localparam logic [ACC_W-1:0] INC3_V   = ACC_W'(FREQ3_INC);

    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] frame_cnt_nxt_c;
    logic [ACC_W-1:0] acc12;
    logic [ACC_W-1:0] acc3;
    logic [ACC_W-1:0] sum12_c;
    logic [ACC_W-1:0] sum3_c;
    logic [ACC_W-1:0] acc12_nxt_c;
    logic [ACC_W-1:0] acc3_nxt_c;
    logic             hit12_c;
    logic             hit3_c;
    logic             hold_c;
    logic             step_req_c;
    logic             step_go_c;
    logic             len_c;
    logic             sweep_c;
    logic             env_c;

`ifdef APU_FRAME_SINGLE_STEP_EN
    logic dbg_req_q;

    // Rising-edge detect on the debug step request
    always_ff @(posedge ac97_bitclk or negedge reset_b) begin
        if (!reset_b) begin
            dbg_req_q <= 1'b0;
        end else begin
            dbg_req_q <= dbg_step_req;
        end
    end

    assign hold_c     = dbg_hold;
    assign step_req_c = dbg_step_req & ~dbg_req_q;
`else
    assign hold_c     = 1'b0;
    assign step_req_c = 1'b0;
`endif

    // Frame prescaler: a step fires on the terminal count, or on a debug request while held
    always_comb begin
        frame_cnt_nxt_c = frame_cnt;
        step_go_c       = 1'b0;
        if (hold_c) begin
            step_go_c = step_req_c;
        end else if (frame_cnt == CNT_LAST) begin
            frame_cnt_nxt_c = '0;
            step_go_c       = 1'b1;
        end else begin
            frame_cnt_nxt_c = frame_cnt + CNT_W'(1);
        end
    end

    // Step schedule, decoded from the step about to execute
    always_comb begin
        len_c   = 1'b0;
        sweep_c = 1'b0;
        env_c   = 1'b0;
        case (frame_step)
            3'd0, 3'd4: len_c = 1'b1;
            3'd2, 3'd6: begin
                len_c   = 1'b1;
                sweep_c = 1'b1;
            end
            3'd7:       env_c = 1'b1;
            default:    ;
        endcase
    end

    // Fractional-N accumulators; ACC_MOD + INC fits in ACC_W so the sum never overflows
    always_comb begin
        sum12_c     = acc12 + INC12_V;
        hit12_c     = (sum12_c >= MOD_V);
        acc12_nxt_c = hit12_c ? (sum12_c - MOD_V) : sum12_c;
        sum3_c      = acc3 + INC3_V;
        hit3_c      = (sum3_c >= MOD_V);
        acc3_nxt_c  = hit3_c ? (sum3_c - MOD_V) : sum3_c;
    end

    // Disable behaves as a synchronous reset so re-enable timing is deterministic
    always_ff @(posedge ac97_bitclk or negedge reset_b) begin
        if (!reset_b) begin
            frame_cnt   <= '0;
            frame_step  <= 3'd0;
            acc12       <= '0;
            acc3        <= '0;
            length_tick <= 1'b0;
            sweep_tick  <= 1'b0;
            env_tick    <= 1'b0;
            freq12_tick <= 1'b0;
            freq3_tick  <= 1'b0;
        end else if (!master_sound_enable) begin
            frame_cnt   <= '0;
            frame_step  <= 3'd0;
            acc12       <= '0;
            acc3        <= '0;
            length_tick <= 1'b0;
            sweep_tick  <= 1'b0;
            env_tick    <= 1'b0;
            freq12_tick <= 1'b0;
            freq3_tick  <= 1'b0;
        end else begin
            frame_cnt   <= frame_cnt_nxt_c;
            length_tick <= step_go_c & len_c;
            sweep_tick  <= step_go_c & sweep_c;
            env_tick    <= step_go_c & env_c;
            if (step_go_c) begin
                frame_step <= frame_step + 3'd1;
            end
            acc12       <= acc12_nxt_c;
            acc3        <= acc3_nxt_c;
            freq12_tick <= hit12_c;
            freq3_tick  <= hit3_c;
        end
    end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Randomized self-checking bench for apu_frame_sequencer against a closed-form timing model.
// Set APU_FRAME_SINGLE_STEP_EN to also exercise the debug single-step ports.
module tb_apu_frame_sequencer;

    localparam int FD    = 400;
    localparam int MOD   = 375;
    localparam int INC12 = 4;
    localparam int INC3  = 2;

    logic       clk = 1'b0;
    logic       reset_b;
    logic       en;
    logic       length_tick;
    logic       sweep_tick;
    logic       env_tick;
    logic       freq12_tick;
    logic       freq3_tick;
    logic [2:0] frame_step;
`ifdef APU_FRAME_SINGLE_STEP_EN
    logic       dbg_hold;
    logic       dbg_step_req;
`endif

    apu_frame_sequencer #(
        .FRAME_DIV  (FD),
        .ACC_MOD    (MOD),
        .FREQ12_INC (INC12),
        .FREQ3_INC  (INC3),
        .ACC_W      (9)
    ) dut (
        .ac97_bitclk         (clk),
        .reset_b             (reset_b),
        .master_sound_enable (en),
`ifdef APU_FRAME_SINGLE_STEP_EN
        .dbg_hold            (dbg_hold),
        .dbg_step_req        (dbg_step_req),
`endif
        .length_tick         (length_tick),
        .sweep_tick          (sweep_tick),
        .env_tick            (env_tick),
        .freq12_tick         (freq12_tick),
        .freq3_tick          (freq3_tick),
        .frame_step          (frame_step)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n     = 0;       // enabled cycles since last reset/disable
    bit use_model = 1'b1;
    int last12 = 0;
    int last3  = 0;
    int cnt_len, cnt_swp, cnt_env, cnt12, cnt3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (n=%0d, t=%0t)", tag, obs, exp, n, $time);
        end
    endtask

    // Expected outputs after n enabled cycles, straight from the timing rules
    task automatic check_model();
        bit step_due;
        int old_step;
        step_due = (n >= FD) && (n % FD == 0);
        old_step = (n / FD + 7) % 8;
        check("len", 32'(length_tick), 32'(step_due && (old_step % 2 == 0)));
        check("swp", 32'(sweep_tick),  32'(step_due && (old_step == 2 || old_step == 6)));
        check("env", 32'(env_tick),    32'(step_due && old_step == 7));
        check("fs",  32'(frame_step),  32'((n / FD) % 8));
        check("f12", 32'(freq12_tick), 32'(n > 0 && ((n * INC12) / MOD != ((n - 1) * INC12) / MOD)));
        check("f3",  32'(freq3_tick),  32'(n > 0 && ((n * INC3) / MOD != ((n - 1) * INC3) / MOD)));
    endtask

    // One clock: advance the model, sample #1 after the edge, compare
    task automatic tick();
        int gap;
        @(posedge clk);
        if (!reset_b || !en) n = 0;
        else n++;
        #1;
        if (use_model) check_model();
        if (n == 0) begin
            last12 = 0;
            last3  = 0;
        end
        cnt_len += int'(length_tick);
        cnt_swp += int'(sweep_tick);
        cnt_env += int'(env_tick);
        cnt12   += int'(freq12_tick);
        cnt3    += int'(freq3_tick);
        if (freq12_tick === 1'b1 && n > 0) begin
            gap = n - last12;
            if (last12 > 0) check("f12_gap", 32'(gap == 93 || gap == 94), 32'd1);
            last12 = n;
        end
        if (freq3_tick === 1'b1 && n > 0) begin
            gap = n - last3;
            if (last3 > 0) check("f3_gap", 32'(gap == 187 || gap == 188), 32'd1);
            last3 = n;
        end
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic clear_counts();
        cnt_len = 0; cnt_swp = 0; cnt_env = 0; cnt12 = 0; cnt3 = 0;
    endtask

    // Async reset between edges; outputs must clear with no clock edge
    task automatic async_reset_pulse();
        #2 reset_b = 1'b0;
        #1;
        n = 0;
        check("arst_len", 32'(length_tick), 32'd0);
        check("arst_f12", 32'(freq12_tick), 32'd0);
        check("arst_f3",  32'(freq3_tick),  32'd0);
        check("arst_fs",  32'(frame_step),  32'd0);
        tick();
        reset_b = 1'b1;
    endtask

    initial begin
        reset_b = 1'b0;
        en      = 1'b0;
`ifdef APU_FRAME_SINGLE_STEP_EN
        dbg_hold     = 1'b0;
        dbg_step_req = 1'b0;
`endif
        clear_counts();
        #1;
        check("rst_len", 32'(length_tick), 32'd0);
        check("rst_fs",  32'(frame_step),  32'd0);
        run(3);

        // Reset mid-count, then release enabled: first length tick on cycle FD+1
        reset_b = 1'b1;
        en      = 1'b1;
        run(150);
        async_reset_pulse();
        run(FD - 1);
        check("first_len_early", 32'(length_tick), 32'd0);
        tick();
        check("first_len", 32'(length_tick), 32'd1);
        check("first_fs",  32'(frame_step),  32'd1);

        // Full eight-step frame
        en = 1'b0;
        tick();
        en = 1'b1;
        clear_counts();
        run(8 * FD);
        check("frame_len_cnt", 32'(cnt_len), 32'd4);
        check("frame_swp_cnt", 32'(cnt_swp), 32'd2);
        check("frame_env_cnt", 32'(cnt_env), 32'd1);
        check("frame_fs_wrap", 32'(frame_step), 32'd0);

        // Long-run tick rates
        en = 1'b0;
        tick();
        en = 1'b1;
        clear_counts();
        run(48000);
        check("f12_count", 32'(cnt12), 32'd512);
        check("f3_count",  32'(cnt3),  32'd256);

        // Disable on the terminal cycle of step 2 suppresses length+sweep
        en = 1'b0;
        tick();
        en = 1'b1;
        run(3 * FD - 1);
        en = 1'b0;
        tick();
        check("dis_len", 32'(length_tick), 32'd0);
        check("dis_swp", 32'(sweep_tick),  32'd0);
        check("dis_fs",  32'(frame_step),  32'd0);
        en = 1'b1;
        run(FD - 1);
        check("reen_len_early", 32'(length_tick), 32'd0);
        tick();
        check("reen_len", 32'(length_tick), 32'd1);
        check("reen_fs",  32'(frame_step),  32'd1);

        // Async reset while freq12_tick is high; accumulator restarts at 0
        for (int i = 0; i < 200 && freq12_tick !== 1'b1; i++) tick();
        check("f12_seen", 32'(freq12_tick), 32'd1);
        async_reset_pulse();
        run(93);
        check("acc_restart_early", 32'(freq12_tick), 32'd0);
        tick();
        check("acc_restart", 32'(freq12_tick), 32'd1);

        // Random enable runs, disables and async resets
        for (int seg = 0; seg < 25; seg++) begin
            en = 1'b1;
            run($urandom_range(1, 1500));
            if ($urandom_range(0, 3) == 0) async_reset_pulse();
            en = 1'b0;
            run($urandom_range(1, 5));
        end

`ifdef APU_FRAME_SINGLE_STEP_EN
        // Held prescaler, three single-step requests: length, none, length+sweep
        begin
            logic [1:0] exp_tab [3];
            exp_tab[0] = 2'b10;
            exp_tab[1] = 2'b00;
            exp_tab[2] = 2'b11;
            use_model = 1'b0;
            en        = 1'b0;
            tick();
            en        = 1'b1;
            dbg_hold  = 1'b1;
            for (int p = 0; p < 3; p++) begin
                clear_counts();
                run(FD + 20);
                check("dbg_quiet", 32'(cnt_len + cnt_swp + cnt_env), 32'd0);
                dbg_step_req = 1'b1;
                tick();
                dbg_step_req = 1'b0;
                check("dbg_len", 32'(length_tick), 32'(exp_tab[p][1]));
                check("dbg_swp", 32'(sweep_tick),  32'(exp_tab[p][0]));
                check("dbg_env", 32'(env_tick),    32'd0);
                check("dbg_fs",  32'(frame_step),  32'(p + 1));
                tick();
                check("dbg_width", 32'(length_tick), 32'd0);
            end
            check("dbg_f12_running", 32'(cnt12 > 0), 32'd1);
            dbg_hold = 1'b0;
            en       = 1'b0;
            tick();
            use_model = 1'b1;
        end
`endif

        run(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
- Single-clock timing controller for the APU channel datapaths (two square channels, waveform player).
- Replaces the chain of derived-clock dividers with one-cycle clock-enable pulses in the ac97_bitclk domain:
  - 512 Hz frame sequencer, scheduling length (256 Hz), sweep (128 Hz) and envelope (64 Hz) events.
  - Exact fractional-N frequency-timer ticks: 131072 Hz for ch1/ch2, 65536 Hz for ch3.
- All channels consume ticks as synchronous enables; no generated clocks.

Parameters:
- FRAME_DIV, 24000: ac97_bitclk cycles per frame step (12.288 MHz / 512 Hz).
- ACC_MOD, 375: fractional accumulator modulus.
- FREQ12_INC, 4: accumulator increment for the ch1/ch2 tick (12.288 MHz × 4/375 = 131072 Hz).
- FREQ3_INC, 2: accumulator increment for the ch3 tick (65536 Hz).
- ACC_W, 9: accumulator width. Requires ACC_MOD + max INC < 2^ACC_W.

Ports:
- ac97_bitclk  input  1  sole clock.
- reset_b  input  1  asynchronous active-low reset.
- master_sound_enable  input  1  APU power (NR52 bit 7); low holds the sequencer idle.
- length_tick  output  1  one-cycle pulse, length counters.
- sweep_tick  output  1  one-cycle pulse, ch1 frequency sweep.
- env_tick  output  1  one-cycle pulse, volume envelopes.
- freq12_tick  output  1  one-cycle pulse at 131072 Hz average.
- freq3_tick  output  1  one-cycle pulse at 65536 Hz average.
- frame_step  output  3  step about to execute (0..7), for debug/chipscope.

Behaviour:
- Reset (reset_b low, asynchronous):
  - All outputs 0.
  - frame_cnt = 0, frame_step = 0, acc12 = 0, acc3 = 0.
- Disabled (master_sound_enable low, sampled each cycle):
  - Same register values as reset, synchronously. No ticks are issued.
  - A disable in the same cycle as a would-be tick suppresses that tick.
- Frame prescaler:
  - frame_cnt counts 0..FRAME_DIV-1 while enabled.
  - On the cycle frame_cnt == FRAME_DIV-1: frame_cnt wraps to 0, frame_step increments mod 8, and step ticks for the old frame_step are registered.
  - The registered ticks are high during the following cycle only.
- Step schedule (old frame_step → ticks):
  - 0 → length
  - 1 → none
  - 2 → length + sweep
  - 3 → none
  - 4 → length
  - 5 → none
  - 6 → length + sweep
  - 7 → env
- Frame latency: after master_sound_enable rises, the first length_tick is high during enabled cycle FRAME_DIV+1 (the rising cycle counts as 1). Each step tick is 1 cycle wide, spaced FRAME_DIV cycles apart.
- Fractional accumulators (each independent, every enabled cycle):
  - sum = acc + INC.
  - If sum >= ACC_MOD: acc <= sum − ACC_MOD and the tick register <= 1.
  - Else: acc <= sum and the tick register <= 0.
  - Tick output is the registered value.
  - freq12: first tick visible after 94 enabled cycles; intervals are 93 or 94 cycles; exactly 512 ticks per 48000 cycles.
  - freq3: intervals are 187 or 188 cycles; exactly 256 ticks per 48000 cycles.
- Simultaneous events: step ticks and freq ticks are independent and may coincide; no priority or merging.
- Re-enable: always restarts from frame_step 0 and acc = 0, so the timing is deterministic.
- Reset asserted mid-operation aborts any pending tick immediately.

Optional Feature:
- Macro: APU_FRAME_SINGLE_STEP_EN.
- Defined: adds the following ports:
  - dbg_hold  input  1
  - dbg_step_req  input  1
- While dbg_hold is high:
  - frame_cnt freezes and no prescaler-driven step occurs.
  - A dbg_step_req rising edge (edge-detected internally; requires dbg_step_req low in the preceding cycle) executes exactly one step: same schedule, same one-cycle tick timing, frame_step += 1.
  - The freq accumulators keep running.
- Undefined: ports absent; the prescaler always runs while enabled.

Test Plan:
- Reset with reset_b=0 mid-count, then release with enable=1 → all outputs 0 during reset; first length_tick at cycle 24001, frame_step=1 afterwards.
- Run 8 steps (192000 cycles) → 4 length_tick, 2 sweep_tick (after steps 2 and 6), 1 env_tick (after step 7); frame_step back to 0.
- Count ticks over 48000 cycles → freq12_tick = 512 and freq3_tick = 256. Every freq12 interval is 93 or 94 cycles; every freq3 interval is 187 or 188 cycles.
- Drop master_sound_enable on the FRAME_DIV-1 cycle of step 2 → no length or sweep pulse; after re-enable, frame_step=0 and the first tick arrives 24000 cycles later.
- Assert reset_b low asynchronously while freq12_tick is high → tick clears without a clock edge; the accumulator restarts at 0.
- With APU_FRAME_SINGLE_STEP_EN: dbg_hold=1, three dbg_step_req pulses → length, none, length+sweep; no ticks between pulses.
